// File: rtl/navic_l1_prn_seq_gen.sv
// NavIC L1 ranging-code generator: emits one chip per enabled clock from the R0/R1/C registers.
// Optional define PRN_SNAPSHOT_EN adds first/last 24-chip capture outputs.
module navic_l1_prn_seq_gen #(
    parameter int unsigned R_LEN    = 55,
    parameter int unsigned C_LEN    = 5,
    parameter int unsigned CODE_LEN = 10230,
    parameter int unsigned IDX_W    = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [R_LEN-1:0]   r0_init,
    input  logic [R_LEN-1:0]   r1_init,
    input  logic [C_LEN-1:0]   c_init,
    input  logic               cont,
    input  logic               chip_en,
    output logic               chip_out,
    output logic               chip_valid,
    output logic [IDX_W-1:0]   chip_idx,
    output logic               epoch,
    output logic               busy
`ifdef PRN_SNAPSHOT_EN
    ,
    output logic [0:23]        first,
    output logic [0:23]        last
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e             r_state;
    state_e             w_state_next;

    logic [R_LEN-1:0]   r_r0;
    logic [R_LEN-1:0]   r_r1;
    logic [C_LEN-1:0]   r_c;
    logic [R_LEN-1:0]   r_r0_seed;
    logic [R_LEN-1:0]   r_r1_seed;
    logic [C_LEN-1:0]   r_c_seed;
    logic [IDX_W-1:0]   r_cnt;

    logic               r_chip_out;
    logic               r_chip_valid;
    logic [IDX_W-1:0]   r_chip_idx;
    logic               r_epoch;

    logic               w_at_last;
    logic               w_start;
    logic               w_emit;
    logic               w_wrap;
    logic               w_busy;
    logic               w_chip;
    logic               w_r0_fb;
    logic               w_r1_fb;
    logic               w_s2;

    assign w_at_last = (r_cnt == LAST_IDX);
    assign w_chip    = r_r1[0] ^ r_c[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Load always wins: it restarts from either state and suppresses the wrap exit.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (load) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (!load && chip_en && w_at_last && !cont) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_start = load;
        w_emit  = 1'b0;
        w_busy  = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_emit = 1'b0;
                w_busy = 1'b0;
            end
            StRun: begin
                w_emit = chip_en && !load;
                w_busy = 1'b1;
            end
            default: begin
                w_emit = 1'b0;
                w_busy = 1'b0;
            end
        endcase
        w_wrap = w_emit && w_at_last;
    end

    always_comb begin
        w_r0_fb = r_r0[50] ^ r_r0[45] ^ r_r0[40] ^ r_r0[20] ^ r_r0[10] ^ r_r0[5] ^ r_r0[0];
        w_s2    = ((r_r0[50] ^ r_r0[45] ^ r_r0[40]) & (r_r0[20] ^ r_r0[10] ^ r_r0[5] ^ r_r0[0]))
                ^ (((r_r0[50] ^ r_r0[45]) & r_r0[40]) ^ ((r_r0[20] ^ r_r0[10]) & (r_r0[5] ^ r_r0[0])))
                ^ ((r_r0[50] & r_r0[45]) ^ (r_r0[20] & r_r0[10]) ^ (r_r0[5] & r_r0[0]));
        w_r1_fb = w_s2 ^ r_r0[40] ^ r_r0[35] ^ r_r0[30] ^ r_r0[25] ^ r_r0[15] ^ r_r0[0]
                ^ r_r1[50] ^ r_r1[45] ^ r_r1[40] ^ r_r1[20] ^ r_r1[10] ^ r_r1[5] ^ r_r1[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r0      <= '0;
            r_r1      <= '0;
            r_c       <= '0;
            r_r0_seed <= '0;
            r_r1_seed <= '0;
            r_c_seed  <= '0;
            r_cnt     <= '0;
        end else if (w_start) begin
            r_r0      <= r0_init;
            r_r1      <= r1_init;
            r_c       <= c_init;
            r_r0_seed <= r0_init;
            r_r1_seed <= r1_init;
            r_c_seed  <= c_init;
            r_cnt     <= '0;
        end else if (w_emit) begin
            if (w_wrap && cont) begin
                r_r0 <= r_r0_seed;
                r_r1 <= r_r1_seed;
                r_c  <= r_c_seed;
            end else begin
                r_r0 <= {w_r0_fb, r_r0[R_LEN-1:1]};
                r_r1 <= {w_r1_fb, r_r1[R_LEN-1:1]};
                r_c  <= {r_c[0], r_c[C_LEN-1:1]};
            end
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chip_out   <= 1'b0;
            r_chip_valid <= 1'b0;
            r_chip_idx   <= '0;
            r_epoch      <= 1'b0;
        end else begin
            r_chip_valid <= w_emit;
            r_epoch      <= w_wrap;
            if (w_emit) begin
                r_chip_out <= w_chip;
                r_chip_idx <= r_cnt;
            end
        end
    end

    assign chip_out   = r_chip_out;
    assign chip_valid = r_chip_valid;
    assign chip_idx   = r_chip_idx;
    assign epoch      = r_epoch;
    assign busy       = w_busy;

`ifdef PRN_SNAPSHOT_EN
    logic [0:23] r_first;
    logic [0:23] r_last;
    logic        w_first_hit;
    logic        w_last_hit;
    logic [4:0]  w_first_sel;
    logic [4:0]  w_last_sel;
    int          w_last_pos;

    // last[] covers chip positions CODE_LEN-24 .. CODE_LEN-1.
    always_comb begin
        w_last_pos  = int'(r_cnt) + 24 - int'(CODE_LEN);
        w_first_hit = w_emit && (int'(r_cnt) < 24);
        w_last_hit  = w_emit && (w_last_pos >= 0) && (w_last_pos < 24);
        w_first_sel = 5'(r_cnt);
        w_last_sel  = w_last_pos[4:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first <= '0;
            r_last  <= '0;
        end else begin
            if (w_first_hit) begin
                r_first[w_first_sel] <= w_chip;
            end
            if (w_last_hit) begin
                r_last[w_last_sel] <= w_chip;
            end
        end
    end

    assign first = r_first;
    assign last  = r_last;
`endif

endmodule

// File: tb/tb_navic_l1_prn_seq_gen.sv
// Self-checking bench: short-epoch DUT checked every cycle against a sequence model,
// full-length DUT checked chip-by-chip against a precomputed 10230-chip code.
module tb_navic_l1_prn_seq_gen;

    localparam int S_LEN = 16;
    localparam int F_LEN = 10230;

    localparam logic [54:0] M_R0 = (55'd1 << 50) | (55'd1 << 45) | (55'd1 << 40) | (55'd1 << 20)
                                 | (55'd1 << 10) | (55'd1 << 5) | 55'd1;
    localparam logic [54:0] M_X  = (55'd1 << 40) | (55'd1 << 35) | (55'd1 << 30) | (55'd1 << 25)
                                 | (55'd1 << 15) | 55'd1;

    typedef struct packed {
        logic [54:0] a;
        logic [54:0] b;
        logic [4:0]  c;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s_load = 0, s_cont = 0, s_en = 0;
    logic [54:0] s_r0 = '0, s_r1 = '0;
    logic [4:0]  s_c = '0;
    logic        s_chip, s_valid, s_epoch, s_busy;
    logic [3:0]  s_idx;

    logic        f_load = 0, f_cont = 0, f_en = 0;
    logic [54:0] f_r0 = '0, f_r1 = '0;
    logic [4:0]  f_c = '0;
    logic        f_chip, f_valid, f_epoch, f_busy;
    logic [13:0] f_idx;

    navic_l1_prn_seq_gen #(.R_LEN(55), .C_LEN(5), .CODE_LEN(S_LEN), .IDX_W(4)) u_dut_s (
        .clk(clk), .rst(rst), .load(s_load), .r0_init(s_r0), .r1_init(s_r1), .c_init(s_c),
        .cont(s_cont), .chip_en(s_en), .chip_out(s_chip), .chip_valid(s_valid),
        .chip_idx(s_idx), .epoch(s_epoch), .busy(s_busy)
    );

    navic_l1_prn_seq_gen u_dut_f (
        .clk(clk), .rst(rst), .load(f_load), .r0_init(f_r0), .r1_init(f_r1), .c_init(f_c),
        .cont(f_cont), .chip_en(f_en), .chip_out(f_chip), .chip_valid(f_valid),
        .chip_idx(f_idx), .epoch(f_epoch), .busy(f_busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    bit code_s [S_LEN];
    bit code_f [F_LEN];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One generator step, straight from the register definitions.
    function automatic st_t adv(input st_t s);
        st_t         n;
        logic [54:0] a;
        logic        f0, f1, s2;
        a  = s.a;
        f0 = ^(a & M_R0);
        s2 = ((a[50] ^ a[45] ^ a[40]) & (a[20] ^ a[10] ^ a[5] ^ a[0]))
           ^ (((a[50] ^ a[45]) & a[40]) ^ ((a[20] ^ a[10]) & (a[5] ^ a[0])))
           ^ ((a[50] & a[45]) ^ (a[20] & a[10]) ^ (a[5] & a[0]));
        f1 = s2 ^ (^(a & M_X)) ^ (^(s.b & M_R0));
        n.a = {f0, a[54:1]};
        n.b = {f1, s.b[54:1]};
        n.c = {s.c[0], s.c[4:1]};
        return n;
    endfunction

    task automatic gen_code(input int len, input logic [54:0] a0, input logic [54:0] b0,
                            input logic [4:0] c0, input bit full);
        st_t s;
        s.a = a0;
        s.b = b0;
        s.c = c0;
        for (int k = 0; k < len; k++) begin
            if (full) code_f[k] = s.b[0] ^ s.c[0];
            else      code_s[k] = s.b[0] ^ s.c[0];
            s = adv(s);
        end
    endtask

    function automatic logic [54:0] rnd55();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[54:0];
    endfunction

    // Stream model for the short-epoch DUT: which chip of the epoch comes next.
    bit         m_run = 0, m_valid = 0, m_epoch = 0, m_chip = 0;
    int         m_k = 0;
    logic [3:0] m_idx = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_run = 0; m_valid = 0; m_epoch = 0; m_chip = 0; m_idx = '0; m_k = 0;
            end else if (s_load) begin
                gen_code(S_LEN, s_r0, s_r1, s_c, 1'b0);
                m_run = 1; m_k = 0; m_valid = 0; m_epoch = 0;
            end else if (m_run && s_en) begin
                m_chip  = code_s[m_k];
                m_idx   = 4'(m_k);
                m_valid = 1;
                m_epoch = (m_k == S_LEN - 1);
                if (m_k == S_LEN - 1) begin
                    m_k = 0;
                    if (!s_cont) m_run = 0;
                end else begin
                    m_k++;
                end
            end else begin
                m_valid = 0;
                m_epoch = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("stream", {56'b0, s_busy, s_valid, s_epoch, s_chip, s_idx},
              {56'b0, m_run, m_valid, m_epoch, m_chip, m_idx});
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    int          nvalid, nepoch, nchip;
    logic [15:0] e1, e2, ecode;
    logic        c0, found;
    st_t         p;

    initial begin
        // Model pins against hand-derived feedback values.
        p.a = (55'd1 << 50) | (55'd1 << 20); p.b = '0; p.c = '0;
        p = adv(p);
        check("pin_s2a", {62'b0, p.a[54], p.b[54]}, 64'b01);
        p.a = (55'd1 << 50) | (55'd1 << 45); p.b = '0; p.c = '0;
        p = adv(p);
        check("pin_s2c", {62'b0, p.a[54], p.b[54]}, 64'b01);
        p.a = (55'd1 << 50) | (55'd1 << 40); p.b = '0; p.c = '0;
        p = adv(p);
        check("pin_s2b", {62'b0, p.a[54], p.b[54]}, 64'b00);
        p.a = 55'd1 << 40; p.b = '0; p.c = '0;
        p = adv(p);
        check("pin_lin", {62'b0, p.a[54], p.b[54]}, 64'b11);
        gen_code(S_LEN, '0, 55'd2, 5'd0, 1'b0);
        check("pin_code", {61'b0, code_s[0], code_s[1], code_s[2]}, 64'b010);

        #2;
        check("reset_s", {56'b0, s_busy, s_valid, s_epoch, s_chip, s_idx}, 64'd0);
        check("reset_f", {46'b0, f_busy, f_valid, f_epoch, f_chip, f_idx}, 64'd0);
        cyc(); cyc();
        rst = 0;

        // One-shot, C[0]=1 walking bit: chips 1,0,0,0,0 repeating.
        cyc();
        s_r0 = '0; s_r1 = '0; s_c = 5'b00001; s_cont = 0; s_load = 1;
        cyc();
        s_load = 0; s_en = 1;
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (s_valid) nvalid++;
            if (i < S_LEN) check("oneshot_chip", {63'b0, s_chip}, {63'b0, (i % 5) == 0});
            if (i == S_LEN - 1) check("oneshot_epoch", {63'b0, s_epoch}, 64'd1);
        end
        check("oneshot_count", 64'(nvalid), 64'd16);
        check("oneshot_idle", {61'b0, s_busy, s_chip, s_valid}, 64'b010);

        // Continuous with toggling enable: two full epochs in 80 cycles.
        s_en = 0;
        s_r0 = rnd55(); s_r1 = rnd55(); s_c = 5'($urandom()); s_cont = 1; s_load = 1;
        cyc();
        s_load = 0;
        nepoch = 0; nchip = 0; e1 = '0; e2 = '0;
        for (int i = 0; i < 80; i++) begin
            s_en = (i % 2 == 0);
            cyc();
            if (s_epoch) nepoch++;
            if (s_valid) begin
                if (nchip < 16) e1[s_idx] = s_chip;
                else if (nchip < 32) e2[s_idx] = s_chip;
                nchip++;
            end
        end
        for (int k = 0; k < S_LEN; k++) ecode[k] = code_s[k];
        check("cont_epochs", 64'(nepoch), 64'd2);
        check("cont_chips", 64'(nchip), 64'd40);
        check("epoch1_code", {48'b0, e1}, {48'b0, ecode});
        check("epoch_repeat", {48'b0, e2}, {48'b0, e1});

        // Restart with the same seeds at idx 7.
        s_en = 0; s_load = 1;
        cyc();
        s_load = 0; s_en = 1;
        found = 0; c0 = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (s_valid && s_idx == 4'd0) c0 = s_chip;
            if (s_valid && s_idx == 4'd7) found = 1;
        end
        check("find_idx7", {63'b0, found}, 64'd1);
        s_load = 1;
        cyc();
        check("load_no_chip", {63'b0, s_valid}, 64'd0);
        s_load = 0;
        cyc();
        check("restart_chip0", {58'b0, s_valid, s_chip, s_idx}, {58'b0, 1'b1, c0, 4'd0});

        // Load coinciding with the epoch-wrap chip: no chip, no epoch.
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (s_valid && s_idx == 4'd14) found = 1;
        end
        check("find_idx14", {63'b0, found}, 64'd1);
        s_load = 1;
        cyc();
        check("load_wins_epoch", {62'b0, s_valid, s_epoch}, 64'd0);
        s_load = 0;
        cyc();
        check("after_load_idx0", {59'b0, s_valid, s_idx}, {59'b0, 1'b1, 4'd0});

        // Asynchronous reset mid-epoch.
        repeat (3) cyc();
        rst = 1;
        #1;
        check("rst_async", {56'b0, s_busy, s_valid, s_epoch, s_chip, s_idx}, 64'd0);
        cyc();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("post_rst_idle", {62'b0, s_busy, s_valid}, 64'd0);
        end
        s_en = 0;
        s_r0 = rnd55(); s_r1 = rnd55(); s_c = 5'($urandom()); s_cont = 0; s_load = 1;
        cyc();
        s_load = 0; s_en = 1;
        repeat (20) cyc();
        s_en = 0;

        // Full-length epoch, all-ones overlay, one-shot.
        f_r0 = '0; f_r1 = '0; f_c = 5'b11111; f_cont = 0; f_load = 1;
        cyc();
        f_load = 0; f_en = 1;
        for (int i = 0; i < F_LEN; i++) begin
            cyc();
            check("full_ones", {46'b0, f_valid, f_epoch, f_chip, 1'b0, f_idx},
                  {46'b0, 1'b1, i == F_LEN - 1, 1'b1, 1'b0, 14'(i)});
        end
        check("full_busy_drop", {63'b0, f_busy}, 64'd0);
        repeat (3) begin
            cyc();
            check("full_ignore_en", {62'b0, f_busy, f_valid}, 64'd0);
        end

        // Full-length random seeds, continuous, into the second epoch.
        f_en = 0;
        f_r0 = rnd55(); f_r1 = rnd55(); f_c = 5'($urandom()); f_cont = 1; f_load = 1;
        gen_code(F_LEN, f_r0, f_r1, f_c, 1'b1);
        cyc();
        f_load = 0; f_en = 1;
        for (int i = 0; i < F_LEN + 20; i++) begin
            cyc();
            check("full_rand", {47'b0, f_valid, f_epoch, f_chip, f_idx},
                  {47'b0, 1'b1, (i % F_LEN) == F_LEN - 1, code_f[i % F_LEN], 14'(i % F_LEN)});
        end
        f_en = 0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
